// File: rtl/dm_result_checker.sv
// dm_result_checker: end-of-program data-memory checker. Once the core raises
// done, walks an N_CHK-entry expected table, reads each address through the
// memory's second read port and reports per-entry mismatches, a count and a
// pass flag. Reads assume a one-cycle memory latency.
module dm_result_checker #(
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int N_CHK      = 3,
    parameter int SETTLE_CYC = 2,
    localparam int IW        = (N_CHK > 1) ? $clog2(N_CHK) : 1,
    localparam int CW        = $clog2(N_CHK + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic             exp_wr_en,
    input  logic [IW-1:0]    exp_wr_idx,
    input  logic [AW-1:0]    exp_wr_addr,
    input  logic [DW-1:0]    exp_wr_data,
    input  logic             exp_wr_care,
    output logic [AW-1:0]    rd_addr,
    input  logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             check_done,
    output logic [N_CHK-1:0] err_vec,
    output logic [CW-1:0]    err_count,
    output logic             pass
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_READ   = 3'd2;
    localparam logic [2:0] ST_CMP    = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             busy_q, busy_d;
    logic             check_done_q, check_done_d;
    logic [N_CHK-1:0] err_vec_q, err_vec_d;
    logic [CW-1:0]    err_count_q, err_count_d;
    logic             pass_q, pass_d;

    logic [AW-1:0]    tbl_addr_q [N_CHK];
    logic [AW-1:0]    tbl_addr_d [N_CHK];
    logic [DW-1:0]    tbl_data_q [N_CHK];
    logic [DW-1:0]    tbl_data_d [N_CHK];
    logic             tbl_care_q [N_CHK];
    logic             tbl_care_d [N_CHK];

    logic             wr_ok_s;

    // Table writes only land while no walk is in flight and the index is in range.
    always_comb begin
        wr_ok_s = exp_wr_en
                  && ((state_q == ST_IDLE) || (state_q == ST_REPORT))
                  && (int'(exp_wr_idx) < N_CHK);
        for (int i = 0; i < N_CHK; i++) begin
            if (wr_ok_s && (int'(exp_wr_idx) == i)) begin
                tbl_addr_d[i] = exp_wr_addr;
                tbl_data_d[i] = exp_wr_data;
                tbl_care_d[i] = exp_wr_care;
            end else begin
                tbl_addr_d[i] = tbl_addr_q[i];
                tbl_data_d[i] = tbl_data_q[i];
                tbl_care_d[i] = tbl_care_q[i];
            end
        end
    end

    // Check sequencer: settle delay, then READ/CMP per entry, then report.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rd_addr_d    = rd_addr_q;
        busy_d       = busy_q;
        check_done_d = check_done_q;
        err_vec_d    = err_vec_q;
        err_count_d  = err_count_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (done) begin
                    state_d      = ST_SETTLE;
                    cnt_d        = 4'(SETTLE_CYC);
                    idx_d        = '0;
                    busy_d       = 1'b1;
                    check_done_d = 1'b0;
                    err_vec_d    = '0;
                    err_count_d  = '0;
                    pass_d       = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    // Address goes out on entry to READ so data is back for CMP.
                    state_d   = ST_READ;
                    rd_addr_d = tbl_addr_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_READ: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (tbl_care_q[idx_q] && (rd_data != tbl_data_q[idx_q])) begin
                    err_vec_d[idx_q] = 1'b1;
                    err_count_d      = err_count_q + CW'(1);
                end else begin
                    err_count_d = err_count_q;
                end
                if (idx_q == IW'(N_CHK - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    state_d   = ST_READ;
                    idx_d     = idx_q + IW'(1);
                    rd_addr_d = tbl_addr_q[idx_q + IW'(1)];
                end
            end
            ST_REPORT: begin
                check_done_d = 1'b1;
                busy_d       = 1'b0;
                pass_d       = (err_count_q == CW'(0));
                if (!done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REPORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, result and table registers; async active-low reset clears all.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            rd_addr_q    <= '0;
            busy_q       <= 1'b0;
            check_done_q <= 1'b0;
            err_vec_q    <= '0;
            err_count_q  <= '0;
            pass_q       <= 1'b0;
            for (int i = 0; i < N_CHK; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
                tbl_care_q[i] <= 1'b0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rd_addr_q    <= rd_addr_d;
            busy_q       <= busy_d;
            check_done_q <= check_done_d;
            err_vec_q    <= err_vec_d;
            err_count_q  <= err_count_d;
            pass_q       <= pass_d;
            for (int i = 0; i < N_CHK; i++) begin
                tbl_addr_q[i] <= tbl_addr_d[i];
                tbl_data_q[i] <= tbl_data_d[i];
                tbl_care_q[i] <= tbl_care_d[i];
            end
        end
    end

    assign rd_addr    = rd_addr_q;
    assign busy       = busy_q;
    assign check_done = check_done_q;
    assign err_vec    = err_vec_q;
    assign err_count  = err_count_q;
    assign pass       = pass_q;

endmodule

// File: doc/dm_result_checker.md
# dm_result_checker

Synthesisable, parametrised result checker that sits beside `top_level` and compares data-memory contents against a preloaded expected table once the core raises `done`. It generalises the fixed three-word end-of-program check into N_CHK entries, each with a configurable address, expected value and care bit. It reports per-entry errors, an error count and a pass flag. Memory access is through a read-only port onto the data memory's second read path.

## Interface
- DW, 8, data word width
- AW, 8, data-memory address width
- N_CHK, 3, number of check entries (1..64)
- SETTLE_CYC, 2, idle cycles between `done` sampled high and the first read (0..15)
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- done  input  1  core program-complete flag, level
- exp_wr_en  input  1  expected-table write strobe
- exp_wr_idx  input  $clog2(N_CHK)  entry index to write
- exp_wr_addr  input  AW  memory address checked by that entry
- exp_wr_data  input  DW  expected value
- exp_wr_care  input  1  1 = entry is checked, 0 = entry is skipped
- rd_addr  output  AW  data-memory read address
- rd_data  input  DW  read data, valid one cycle after rd_addr
- busy  output  1  check in progress
- check_done  output  1  results valid
- err_vec  output  N_CHK  bit i set when entry i mismatched
- err_count  output  $clog2(N_CHK+1)  number of set bits in err_vec
- pass  output  1  check_done and err_count==0

## Operation
- Expected table: N_CHK entries of {addr, data, care}. Reset clears every field to 0.
- Table writes are accepted only in IDLE or REPORT.
  - Writes in SETTLE, READ or CMP are ignored.
  - Writes with exp_wr_idx >= N_CHK are ignored.
- FSM states: IDLE, SETTLE, READ, CMP, REPORT.
- IDLE:
  - If done==1, go to SETTLE.
  - On this transition, clear err_vec, err_count, pass and check_done, load the settle counter with SETTLE_CYC, set idx=0 and assert busy.
- SETTLE:
  - Decrement the settle counter each cycle.
  - When the counter is 0, go to READ. With SETTLE_CYC=0, SETTLE lasts exactly one cycle.
- READ: drive rd_addr = table[idx].addr, then go to CMP.
- CMP:
  - If care==1 and rd_data != table[idx].data, set err_vec[idx] and increment err_count.
  - If idx==N_CHK-1, go to REPORT. Otherwise increment idx and go to READ.
- REPORT:
  - Set check_done=1 and busy=0; pass = (err_count==0).
  - Results hold while done==1.
  - When done==0, go to IDLE. Results remain visible until the next run starts.
- done is sampled only in IDLE and REPORT. If done drops during SETTLE, READ or CMP, the run still completes.
- If all entries have care==0, the run completes with pass=1.
- rd_addr holds its last value outside READ.
- Arithmetic and widths:
  - Comparison is exact over DW bits.
  - err_count cannot overflow because its width covers N_CHK.
  - idx has width $clog2(N_CHK) and never wraps past N_CHK-1.

## Timing
- Reset values: rd_addr=0, busy=0, check_done=0, err_vec=0, err_count=0, pass=0, state=IDLE.
- Reset assertion mid-run forces the reset values immediately (asynchronously). After reset releases, the block is in IDLE and needs a fresh done level.
- Let cycle 0 be the rising edge on which done is sampled high in IDLE.
  - SETTLE occupies cycles 1..SETTLE_CYC+1.
  - Each entry takes 2 cycles (READ, then CMP).
  - check_done rises at cycle SETTLE_CYC + 2 + 2·N_CHK.
  - With the defaults this is cycle 10.
- Results register in CMP; err_vec and err_count update on the edge that ends CMP.
- A table write accepted in REPORT takes effect in the next run only; current results are unchanged.
- If done is still high when the block returns from REPORT to IDLE, no new run starts. A new run needs done to go 0 (REPORT→IDLE) and then 1 again.

## Test plan
- Load entries {0:15, 1:4, 2:20} with care=1, memory holding 15/4/20, raise done.
  - check_done rises at cycle 10.
  - err_vec=000, err_count=0, pass=1.
- Same table, memory[1]=5.
  - err_vec=010, err_count=1, pass=0.
- Memory[1]=5 with entry 1 care=0.
  - pass=1, err_vec=000.
- Drop done at cycle 5 of a run.
  - The run still completes at cycle 10.
  - The block returns to IDLE next cycle and results persist.
- Assert reset (0) at cycle 6 of a run.
  - All outputs return to 0 immediately and the table is cleared.
  - After release and a done pulse, pass=1 because all entries have care=0.
- Issue exp_wr_en in READ, and with exp_wr_idx=3 in IDLE.
  - Both writes are ignored; the table is unchanged and the verdict matches the prior load.
